// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if
// Bundles the signals between the measurement sequencer and the outside world:
// requests from the front panel (start, cont), the counter-chain feedback
// (din, co), the counter controls (en, cnt_clear_n) and the display-side
// result (dout, ovf, valid, busy).
//   master : the sequencer (gate_ctrl) side
//   slave  : the counter chain / display / requester side
interface gate_ctrl_if;
   logic        start;
   logic        cont;
   logic [15:0] din;
   logic        co;
   logic        en;
   logic        cnt_clear_n;
   logic [15:0] dout;
   logic        ovf;
   logic        valid;
   logic        busy;

   modport master (
      input  start, cont, din, co,
      output en, cnt_clear_n, dout, ovf, valid, busy
   );

   modport slave (
      output start, cont, din, co,
      input  en, cnt_clear_n, dout, ovf, valid, busy
   );
endinterface

// File: rtl/gate_ctrl.sv
// gate_ctrl
// Measurement sequencer for the capacitance meter. Clears the BCD decade
// counter chain, opens a fixed gate window, lets the chain settle, then
// latches the four-digit result and an overflow flag. In continuous mode the
// result is held for a while and the cycle repeats.
// Ports:
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : gate_ctrl_if.master (start, cont, din, co in;
//           en, cnt_clear_n, dout, ovf, valid, busy out)
module gate_ctrl #(
   parameter int CLEAR_CYCLES  = 4,
   parameter int GATE_CYCLES   = 1000000,
   parameter int SETTLE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 500000
) (
   input  logic        clk,
   input  logic        clear,
   gate_ctrl_if.master bus
);

   // One shared duration counter, sized for the longest state.
   localparam int MAX_CG     = (CLEAR_CYCLES > GATE_CYCLES) ? CLEAR_CYCLES : GATE_CYCLES;
   localparam int MAX_SH     = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYCLES = (MAX_CG > MAX_SH) ? MAX_CG : MAX_SH;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [CW-1:0] CLEAR_LOAD  = CW'(CLEAR_CYCLES - 1);
   localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      GATE,
      SETTLE,
      LATCH,
      HOLD
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          sticky, sticky_next;
   logic          cnt_done;

   assign cnt_done = (cnt == '0);

   // Next-state logic. Each timed state is entered with its length minus one
   // loaded into the counter and leaves on the cycle the counter reads zero.
   // The overflow sticky is cleared while counters are being cleared, and
   // collects carries both in the gate and in the settle window so a carry
   // that lags gate close is still seen.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      sticky_next = sticky;
      case (state)
         IDLE: begin
            if (bus.start || bus.cont) begin
               state_next = CLR;
               cnt_next   = CLEAR_LOAD;
            end
         end
         CLR: begin
            sticky_next = 1'b0;
            if (cnt_done) begin
               state_next = GATE;
               cnt_next   = GATE_LOAD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         GATE: begin
            if (bus.co) sticky_next = 1'b1;
            if (cnt_done) begin
               state_next = SETTLE;
               cnt_next   = SETTLE_LOAD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         SETTLE: begin
            if (bus.co) sticky_next = 1'b1;
            if (cnt_done) begin
               state_next = LATCH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         LATCH: begin
            if (bus.cont) begin
               state_next = HOLD;
               cnt_next   = HOLD_LOAD;
            end else begin
               state_next = IDLE;
            end
         end
         HOLD: begin
            if (cnt_done) begin
               if (bus.cont) begin
                  state_next = CLR;
                  cnt_next   = CLEAR_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State register and registered outputs. Outputs are decoded from the
   // current state, so they follow each state change by one cycle; this keeps
   // en and the counter clear mutually exclusive and glitch free.
   always_ff @(posedge clk) begin
      if (clear) begin
         state           <= IDLE;
         cnt             <= '0;
         sticky          <= 1'b0;
         bus.en          <= 1'b0;
         bus.cnt_clear_n <= 1'b0;
         bus.dout        <= 16'h0000;
         bus.ovf         <= 1'b0;
         bus.valid       <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         sticky          <= sticky_next;
         bus.en          <= (state == GATE);
         bus.cnt_clear_n <= (state != CLR);
         bus.busy        <= (state != IDLE);
         bus.valid       <= (state == LATCH);
         if (state == LATCH) begin
            bus.dout <= bus.din;
            bus.ovf  <= sticky;
         end
      end
   end

endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl
// Directed bench for gate_ctrl. DUT a uses short windows (2/20/2/10), DUT b
// has every duration set to 1. Expected results are queued when a
// measurement is requested and checked whenever a DUT raises valid; the
// en / cnt_clear_n / busy / valid waveforms are checked every cycle against
// timing derived from the request edge.
module tb_gate_ctrl;

   localparam int C = 2;
   localparam int G = 20;
   localparam int S = 2;
   localparam int H = 10;

   typedef struct {
      logic [15:0] dout;
      logic        ovf;
   } result_t;

   logic clk = 1'b0;
   logic clear;

   always #5 clk = ~clk;

   gate_ctrl_if ifa ();
   gate_ctrl_if ifb ();

   gate_ctrl #(
      .CLEAR_CYCLES (C),
      .GATE_CYCLES  (G),
      .SETTLE_CYCLES(S),
      .HOLD_CYCLES  (H)
   ) dut_a (
      .clk  (clk),
      .clear(clear),
      .bus  (ifa.master)
   );

   gate_ctrl #(
      .CLEAR_CYCLES (1),
      .GATE_CYCLES  (1),
      .SETTLE_CYCLES(1),
      .HOLD_CYCLES  (1)
   ) dut_b (
      .clk  (clk),
      .clear(clear),
      .bus  (ifb.master)
   );

   result_t q_a[$];
   result_t q_b[$];
   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Single comparison point: counts the vector and reports a miscompare.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Advance one clock, sample just after the edge, and pop the scoreboard
   // for any DUT that presents a result.
   task automatic tick();
      result_t r;
      @(posedge clk);
      #1;
      cyc++;
      if (ifa.valid === 1'b1) begin
         checkOutput("a_valid_expected", 16'(q_a.size() != 0), 16'd1);
         if (q_a.size() != 0) begin
            r = q_a.pop_front();
            checkOutput("a_dout", ifa.dout, r.dout);
            checkOutput("a_ovf", 16'(ifa.ovf), 16'(r.ovf));
         end
      end
      if (ifb.valid === 1'b1) begin
         checkOutput("b_valid_expected", 16'(q_b.size() != 0), 16'd1);
         if (q_b.size() != 0) begin
            r = q_b.pop_front();
            checkOutput("b_dout", ifb.dout, r.dout);
            checkOutput("b_ovf", 16'(ifb.ovf), 16'(r.ovf));
         end
      end
   endtask

   // Request a measurement (single shot via start, or continuous via cont)
   // and queue the expected results. k is the edge that samples the request.
   task automatic applyStimulus(input int sel, input logic [15:0] din, input logic use_cont,
                                input logic exp_ovf, input int n_results, output int k);
      result_t r;
      r.dout = din;
      r.ovf  = exp_ovf;
      if (sel == 0) begin
         ifa.din   = din;
         ifa.start = !use_cont;
         ifa.cont  = use_cont;
         for (int i = 0; i < n_results; i++) q_a.push_back(r);
      end else begin
         ifb.din   = din;
         ifb.start = !use_cont;
         ifb.cont  = use_cont;
         for (int i = 0; i < n_results; i++) q_b.push_back(r);
      end
      k = cyc + 1;
   endtask

   // Step until cycle k+limit, checking the control waveform each cycle.
   // Request edge k starts period 0; later periods start every P edges.
   task automatic runCheck(input int sel, input int k, input int periods, input int limit,
                           input int start_cyc, input int co_cyc, input int drop_cyc,
                           input int c, input int g, input int s, input int h);
      int   p_len;
      int   d;
      int   p;
      int   o;
      logic e_clr_n, e_en, e_valid, e_busy;
      logic o_clr_n, o_en, o_valid, o_busy;
      p_len = c + g + s + 1 + h;
      while (cyc < k + limit) begin
         tick();
         if (sel == 0) begin
            ifa.start = (cyc == start_cyc);
            ifa.co    = (cyc == co_cyc);
            if (cyc == drop_cyc) ifa.cont = 1'b0;
            o_clr_n = ifa.cnt_clear_n;
            o_en    = ifa.en;
            o_valid = ifa.valid;
            o_busy  = ifa.busy;
         end else begin
            ifb.start = (cyc == start_cyc);
            ifb.co    = (cyc == co_cyc);
            if (cyc == drop_cyc) ifb.cont = 1'b0;
            o_clr_n = ifb.cnt_clear_n;
            o_en    = ifb.en;
            o_valid = ifb.valid;
            o_busy  = ifb.busy;
         end
         d = cyc - k;
         p = (d < 0) ? 0 : d / p_len;
         if (p > periods - 1) p = periods - 1;
         o = d - p * p_len;
         e_clr_n = !(o >= 1 && o <= c);
         e_en    = (o >= c + 1) && (o <= c + g);
         e_valid = (d >= 0) && (o == c + g + s + 1);
         e_busy  = (d >= 1) && (d <= (periods - 1) * p_len + c + g + s + 1);
         checkOutput("cnt_clear_n", 16'(o_clr_n), 16'(e_clr_n));
         checkOutput("en", 16'(o_en), 16'(e_en));
         checkOutput("valid", 16'(o_valid), 16'(e_valid));
         checkOutput("busy", 16'(o_busy), 16'(e_busy));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      clear     = 1'b1;
      ifa.start = 1'b0;
      ifa.cont  = 1'b0;
      ifa.din   = 16'h0000;
      ifa.co    = 1'b0;
      ifb.start = 1'b0;
      ifb.cont  = 1'b0;
      ifb.din   = 16'h0000;
      ifb.co    = 1'b0;

      // Reset and idle
      $display("[TB] reset and idle");
      tick();
      tick();
      checkOutput("rst_en", 16'(ifa.en), 16'd0);
      checkOutput("rst_clr_n", 16'(ifa.cnt_clear_n), 16'd0);
      checkOutput("rst_dout", ifa.dout, 16'h0000);
      checkOutput("rst_ovf", 16'(ifa.ovf), 16'd0);
      checkOutput("rst_valid", 16'(ifa.valid), 16'd0);
      checkOutput("rst_busy", 16'(ifa.busy), 16'd0);
      checkOutput("rst_b_clr_n", 16'(ifb.cnt_clear_n), 16'd0);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("idle_clr_n", 16'(ifa.cnt_clear_n), 16'd1);
         checkOutput("idle_busy", 16'(ifa.busy), 16'd0);
         checkOutput("idle_en", 16'(ifa.en), 16'd0);
         checkOutput("idle_b_clr_n", 16'(ifb.cnt_clear_n), 16'd1);
      end

      // Single shot
      $display("[TB] single shot");
      applyStimulus(0, 16'h0347, 1'b0, 1'b0, 1, k);
      runCheck(0, k, 1, 30, -1, -1, -1, C, G, S, H);
      checkOutput("dout_hold", ifa.dout, 16'h0347);

      // Overflow set by a carry, then cleared by a clean measurement
      $display("[TB] overflow");
      applyStimulus(0, 16'h1234, 1'b0, 1'b1, 1, k);
      runCheck(0, k, 1, 30, -1, k + 12, -1, C, G, S, H);
      checkOutput("ovf_hold", 16'(ifa.ovf), 16'd1);
      applyStimulus(0, 16'hA5F0, 1'b0, 1'b0, 1, k);
      runCheck(0, k, 1, 30, -1, -1, -1, C, G, S, H);

      // Continuous mode, cont dropped in the third gate
      $display("[TB] continuous");
      applyStimulus(0, 16'h0815, 1'b1, 1'b0, 3, k);
      runCheck(0, k, 3, 100, -1, -1, k + 70 + 10, C, G, S, H);

      // start during gate is ignored
      $display("[TB] start during gate");
      applyStimulus(0, 16'h0042, 1'b0, 1'b0, 1, k);
      runCheck(0, k, 1, 60, k + 10, -1, -1, C, G, S, H);

      // clear during gate aborts without a result
      $display("[TB] clear during gate");
      applyStimulus(0, 16'h0999, 1'b0, 1'b0, 0, k);
      tick();
      ifa.start = 1'b0;
      while (cyc < k + 10) tick();
      checkOutput("abort_en_before", 16'(ifa.en), 16'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("abort_en", 16'(ifa.en), 16'd0);
      checkOutput("abort_dout", ifa.dout, 16'h0000);
      checkOutput("abort_busy", 16'(ifa.busy), 16'd0);
      checkOutput("abort_clr_n", 16'(ifa.cnt_clear_n), 16'd0);
      for (int i = 0; i < 30; i++) begin
         tick();
         checkOutput("abort_no_valid", 16'(ifa.valid), 16'd0);
         checkOutput("abort_no_en", 16'(ifa.en), 16'd0);
      end

      // All durations of one cycle
      $display("[TB] unit durations");
      applyStimulus(1, 16'h5678, 1'b0, 1'b0, 1, k);
      runCheck(1, k, 1, 10, -1, -1, -1, 1, 1, 1, 1);
      applyStimulus(1, 16'h1357, 1'b1, 1'b0, 2, k);
      runCheck(1, k, 2, 20, -1, -1, k + 5 + 2, 1, 1, 1, 1);

      checkOutput("a_queue_empty", 16'(q_a.size()), 16'd0);
      checkOutput("b_queue_empty", 16'(q_b.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
